// File: rtl/tape_in.sv
// Cassette input conditioner: two-flop synchroniser, ce-driven deglitch filter,
// half-period measurement between accepted edges and a tape-activity timeout.
module tape_in #(
  parameter int FILTER_LEN  = 4,
  parameter int ACT_TIMEOUT = 6000000,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                enable,
  input  logic                tape_raw,
  output logic                tape_bit,
  output logic                tape_edge,
  output logic                tape_rise,
  output logic [PERIOD_W-1:0] last_period,
  output logic                period_valid,
  output logic                tape_active,
  output logic [1:0]          dbg_state
);

  localparam int ACT_W = (ACT_TIMEOUT < 2) ? 1 : $clog2(ACT_TIMEOUT + 1);
  localparam logic [3:0]          FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [ACT_W-1:0]    ACT_LOAD = ACT_W'(ACT_TIMEOUT);
  localparam logic [PERIOD_W-1:0] PER_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2
  } state_e;

  logic                meta_q, sync_q;
  logic [3:0]          flt_q, flt_d;
  logic [PERIOD_W-1:0] per_q, per_d, per_inc;
  logic [ACT_W-1:0]    act_q, act_d;
  state_e              state_q;
  logic                tape_bit_q, edge_q, rise_q, valid_q, active_q;
  logic [PERIOD_W-1:0] last_q;
  logic                accept, act_expire;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= tape_raw;
      sync_q <= meta_q;
    end
  end

  always_comb begin
    accept = 1'b0;
    flt_d  = flt_q;
    if (!enable) begin
      flt_d = '0;
    end else if (ce) begin
      // Any sample matching the published level restarts the filter.
      if (sync_q == tape_bit_q) begin
        flt_d = '0;
      end else if (flt_q == FLT_LAST) begin
        accept = 1'b1;
        flt_d  = '0;
      end else begin
        flt_d = flt_q + 4'd1;
      end
    end

    per_inc = (per_q == PER_MAX) ? PER_MAX : per_q + PERIOD_W'(1);
    per_d   = per_q;
    if (enable && ce) per_d = accept ? '0 : per_inc;

    act_d = act_q;
    if (!enable)                        act_d = '0;
    else if (accept)                    act_d = ACT_LOAD;
    else if (ce && (act_q != '0))       act_d = act_q - ACT_W'(1);

    act_expire = enable && ce && !accept && (act_q == ACT_W'(1));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      flt_q <= '0;
      per_q <= '0;
      act_q <= '0;
    end else begin
      flt_q <= flt_d;
      per_q <= per_d;
      act_q <= act_d;
    end
  end

  // Measurement FSM; the first edge of a burst only arms the period counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tape_bit_q <= 1'b0;
      edge_q     <= 1'b0;
      rise_q     <= 1'b0;
      last_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      edge_q   <= accept;
      active_q <= (act_d != '0);
      if (accept) begin
        tape_bit_q <= sync_q;
        rise_q     <= sync_q;
      end
      if (!enable) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else if (accept) begin
        unique case (state_q)
          IDLE:  state_q <= FIRST;
          FIRST: begin
            state_q <= TRACK;
            last_q  <= per_inc;
            valid_q <= 1'b1;
          end
          TRACK: last_q <= per_inc;
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end else if (act_expire) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign tape_bit     = tape_bit_q;
  assign tape_edge    = edge_q;
  assign tape_rise    = rise_q;
  assign last_period  = last_q;
  assign period_valid = valid_q;
  assign tape_active  = active_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tape_in.sv
// Bench for tape_in: two instances (16- and 8-bit period counters) share stimulus
// and are compared every ce tick against a tick-level behavioural model.
module tb_tape_in;

  localparam int FL  = 4;
  localparam int ACT = 1000;

  logic clk, reset_n, ce, enable, tape_raw;

  logic        tb16, te16, tr16, pv16, ta16;
  logic [15:0] lp16;
  logic [1:0]  st16;
  logic        tb8, te8, tr8, pv8, ta8;
  logic [7:0]  lp8;
  logic [1:0]  st8;

  tape_in #(.FILTER_LEN(FL), .ACT_TIMEOUT(ACT), .PERIOD_W(16)) dut16 (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .enable(enable), .tape_raw(tape_raw),
    .tape_bit(tb16), .tape_edge(te16), .tape_rise(tr16), .last_period(lp16),
    .period_valid(pv16), .tape_active(ta16), .dbg_state(st16)
  );

  tape_in #(.FILTER_LEN(FL), .ACT_TIMEOUT(ACT), .PERIOD_W(8)) dut8 (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .enable(enable), .tape_raw(tape_raw),
    .tape_bit(tb8), .tape_edge(te8), .tape_rise(tr8), .last_period(lp8),
    .period_valid(pv8), .tape_active(ta8), .dbg_state(st8)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [37:0] obs;
  assign obs = {tb16, te16, tr16, pv16, ta16, st16, lp16, tb8, te8, tr8, pv8, ta8, st8, lp8};

  // Behavioural model, one step per ce tick
  logic        m_bit, m_edge, m_rise, m_valid, m_alive;
  logic [1:0]  m_sess;
  logic [15:0] m_last16;
  logic [7:0]  m_last8;
  int          m_run, m_n, m_act_ticks;

  logic [37:0] exp_q[$];
  logic [37:0] exp_v;
  int checks = 0;
  int errors = 0;

  function automatic logic [37:0] exp_vec();
    return {m_bit, m_edge, m_rise, m_valid, m_alive, m_sess, m_last16,
            m_bit, m_edge, m_rise, m_valid, m_alive, m_sess, m_last8};
  endfunction

  task automatic model_reset();
    m_bit = 0; m_edge = 0; m_rise = 0; m_valid = 0; m_alive = 0; m_sess = 0;
    m_last16 = 0; m_last8 = 0; m_run = 0; m_n = 0; m_act_ticks = 0;
  endtask

  task automatic model_step(input logic level, input logic en);
    m_edge = 0;
    if (!en) begin
      m_run = 0; m_alive = 0; m_valid = 0; m_sess = 0; m_act_ticks = 0;
    end else begin
      m_n++;
      if (level != m_bit) m_run++;
      else                m_run = 0;
      if (m_run == FL) begin
        m_bit = level; m_rise = level; m_edge = 1; m_run = 0;
        if (m_sess >= 1) begin
          m_last16 = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
          m_last8  = (m_n > 255)   ? 8'hFF    : 8'(m_n);
          m_valid  = 1;
        end
        if (m_sess < 2) m_sess = m_sess + 2'd1;
        m_n = 0; m_alive = 1; m_act_ticks = 0;
      end else if (m_alive) begin
        m_act_ticks++;
        if (m_act_ticks == ACT) begin
          m_alive = 0; m_valid = 0; m_sess = 0;
        end
      end
    end
  endtask

  // Driver: the line is held for two clocks ahead of each ce so the synchroniser has settled.
  task automatic tick(input logic level, input logic en);
    @(negedge clk); tape_raw = level; enable = en; ce = 1'b0;
    @(negedge clk);
    @(negedge clk); ce = 1'b1;
    @(posedge clk); #1;
    model_step(level, en);
    exp_q.push_back(exp_vec());
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tape_raw = ~tape_raw; ce = i[0];
      @(posedge clk); #1;
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_hold cyc %0d: got %h expected 0", i, obs); end
    end
    @(negedge clk); tape_raw = 1'b0; ce = 1'b0; reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_release tick %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_glitch();
    int edges = 0;
    for (int i = 0; i < 8; i++) begin
      tick((i < 3) ? 1'b1 : 1'b0, 1'b1);
      if (te16) edges++;
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL glitch tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    checks++;
    if (edges != 0 || tb16 !== 1'b0) begin
      errors++; $display("FAIL glitch_reject: edges %0d bit %b expected 0 edges bit 0", edges, tb16);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL accept tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    checks++;
    if ({tb16, te16, tr16} !== 3'b111) begin
      errors++; $display("FAIL accept_edge: bit/edge/rise %b expected 111", {tb16, te16, tr16});
    end
    @(negedge clk); ce = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (te16 !== 1'b0) begin errors++; $display("FAIL edge_pulse_width: edge %b expected 0", te16); end
  endtask

  task automatic run_wave(input string name, input int half, input int n_half,
                          input logic [15:0] want16, input logic [7:0] want8);
    logic lvl;
    int   edges = 0;
    lvl = ~m_bit;
    for (int h = 0; h < n_half; h++) begin
      for (int i = 0; i < half; i++) begin
        tick(lvl, 1'b1);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL %s half %0d tick %0d: got %h expected %h", name, h, i, obs, exp_v); end
        if (te16) begin
          edges++;
          if (edges >= 2) begin
            checks++;
            if (lp16 !== want16 || lp8 !== want8 || pv16 !== 1'b1) begin
              errors++; $display("FAIL %s_period edge %0d: got %0d/%0d valid %b expected %0d/%0d valid 1",
                                 name, edges, lp16, lp8, pv16, want16, want8);
            end
          end
        end
      end
      lvl = ~lvl;
    end
    checks++;
    if (edges != n_half) begin errors++; $display("FAIL %s_edge_count: got %0d expected %0d", name, edges, n_half); end
  endtask

  task automatic test_period();
    for (int i = 0; i < ACT + 50 && m_alive; i++) begin
      tick(m_bit, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL idle_wait tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    checks++;
    if (st16 !== 2'd0 || pv16 !== 1'b0) begin errors++; $display("FAIL idle_before_wave: state %0d valid %b expected 0 0", st16, pv16); end
    for (int i = 0; i < 10 && !te16; i++) begin
      tick(~m_bit, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL first_edge tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    checks++;
    if (te16 !== 1'b1 || st16 !== 2'd1 || pv16 !== 1'b0) begin
      errors++; $display("FAIL first_edge_state: edge %b state %0d valid %b expected 1 1 0", te16, st16, pv16);
    end
    // Finish the half-period started above so the wave keeps a 600-tick rhythm.
    for (int i = 0; i < 600 - FL; i++) begin
      tick(m_bit, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL period_lead tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    run_wave("period", 600, 4, 16'd600, 8'd255);
  endtask

  task automatic test_saturation();
    run_wave("sat", 300, 4, 16'd300, 8'd255);
  endtask

  task automatic test_timeout();
    logic lvl;
    lvl = ~m_bit;
    for (int i = 0; i < 300; i++) begin
      tick(lvl, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL timeout_edge tick %0d: got %h expected %h", i, obs, exp_v); end
      if (i == FL - 1) begin
        checks++;
        if (te16 !== 1'b1 || lp16 !== 16'd300) begin errors++; $display("FAIL timeout_edge_seen: edge %b period %0d expected 1 300", te16, lp16); end
      end
    end
    for (int k = 300 - FL + 1; k <= ACT; k++) begin
      tick(lvl, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL timeout_hold tick %0d: got %h expected %h", k, obs, exp_v); end
      if (k == ACT - 1) begin
        checks++;
        if (ta16 !== 1'b1) begin errors++; $display("FAIL timeout_early: active %b expected 1", ta16); end
      end
    end
    checks++;
    if ({ta16, st16, pv16} !== 4'b0000 || lp16 !== 16'd300 || lp8 !== 8'd255) begin
      errors++; $display("FAIL timeout_drop: active %b state %0d valid %b period %0d/%0d expected 0 0 0 300/255",
                         ta16, st16, pv16, lp16, lp8);
    end
  endtask

  task automatic test_enable_reset();
    logic lvl, frz;
    int   edges = 0;
    lvl = ~m_bit;
    for (int i = 0; i < 120; i++) begin
      if (i % 40 == 0 && i > 0) lvl = ~lvl;
      tick(lvl, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL en_wave tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    frz = m_bit;
    for (int i = 0; i < 120; i++) begin
      if (i % 40 == 0) lvl = ~lvl;
      tick(lvl, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL en_low tick %0d: got %h expected %h", i, obs, exp_v); end
      if (te16 || ta16 || tb16 !== frz) edges++;
    end
    checks++;
    if (edges != 0) begin errors++; $display("FAIL en_low_frozen: %0d bad ticks expected 0", edges); end
    for (int i = 0; i < 60; i++) begin
      if (i % 30 == 0) lvl = ~lvl;
      tick(lvl, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL en_resume tick %0d: got %h expected %h", i, obs, exp_v); end
    end
    // Asynchronous reset in the middle of a half-period, away from any clock edge.
    @(posedge clk); #3; reset_n = 1'b0; tape_raw = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs); end
    @(negedge clk); ce = 1'b0;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    edges = 0;
    for (int i = 0; i < 160; i++) begin
      tick((i >= 10 && ((i - 10) / 50) % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL post_reset tick %0d: got %h expected %h", i, obs, exp_v); end
      if (te16) begin
        edges++;
        checks++;
        if (edges == 1 && (st16 !== 2'd1 || pv16 !== 1'b0)) begin
          errors++; $display("FAIL post_reset_first: state %0d valid %b expected 1 0", st16, pv16);
        end else if (edges >= 2 && (lp16 !== 16'd50 || lp8 !== 8'd50 || pv16 !== 1'b1)) begin
          errors++; $display("FAIL post_reset_period: got %0d/%0d valid %b expected 50/50 valid 1", lp16, lp8, pv16);
        end
      end
    end
    checks++;
    if (edges != 3) begin errors++; $display("FAIL post_reset_edges: got %0d expected 3", edges); end
  endtask

  task automatic test_random();
    logic lvl, en;
    int   len, total;
    lvl = m_bit; total = 0;
    while (total < 1500) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 60) : $urandom_range(1, 6);
      en  = ($urandom_range(0, 15) != 0);
      lvl = ~lvl;
      for (int i = 0; i < len; i++) begin
        tick(lvl, en);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL random tick %0d: got %h expected %h", total, obs, exp_v); end
        total++;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ce = 1'b0; enable = 1'b1; tape_raw = 1'b0;
    model_reset();
    test_reset();
    test_glitch();
    test_period();
    test_saturation();
    test_timeout();
    test_enable_reset();
    test_random();
    @(negedge clk); ce = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
